// File: rtl/cont12_ctrl_if.sv
// Bundle of host/front-panel controls, counter feedback and counter drive
// for the cont12 run-control sequencer.
interface cont12_ctrl_if #(
  parameter int W = 12
);
  logic         start;
  logic         stop;
  logic         step;
  logic         jmp_req;
  logic [W-1:0] jmp_addr;
  logic         limit_we;
  logic [W-1:0] limit_in;
  logic         wrap_en;
  logic [W-1:0] cont;

  logic         enable;
  logic         loact;
  logic [W-1:0] load;
  logic         busy;
  logic         done;
  logic         jmp_ack;
  logic         jmp_err;
  logic [1:0]   state;

  // Host side: issues commands and supplies the counter read-back.
  modport master (
    output start, stop, step, jmp_req, jmp_addr,
           limit_we, limit_in, wrap_en, cont,
    input  enable, loact, load, busy, done, jmp_ack, jmp_err, state
  );

  // Sequencer side.
  modport slave (
    input  start, stop, step, jmp_req, jmp_addr,
           limit_we, limit_in, wrap_en, cont,
    output enable, loact, load, busy, done, jmp_ack, jmp_err, state
  );
endinterface

// File: rtl/cont12_ctrl.sv
// Run-control sequencer for the 12-bit loadable counter: continuous run,
// single step, jumps and terminate/wrap at a programmable limit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | counter held; jumps serviced; start -> RUN, step -> STEP
// RUN   | counting; stop > jump > at-limit (wrap/done) > increment
// STEP  | one-cycle single increment (or wrap), then back to IDLE
// DONE  | limit reached without wrap; start restarts from 0
module cont12_ctrl #(
  parameter int           W             = 12,
  parameter logic [W-1:0] DEFAULT_LIMIT = 12'hFFF
) (
  input  logic         clk,
  input  logic         reset,
  cont12_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_limit;
  logic         w_at_lim;
  logic         w_jmp_ok;

  // Compare is >= so a limit written below the current count still stops/wraps.
  assign w_at_lim = (bus.cont >= r_limit);
  assign w_jmp_ok = (bus.jmp_addr <= r_limit);

  assign bus.busy  = (r_state == S_RUN) || (r_state == S_STEP);
  assign bus.done  = (r_state == S_DONE);
  assign bus.state = r_state;

  // State and limit registers; a limit write takes effect next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_limit <= DEFAULT_LIMIT;
    end else begin
      r_state <= w_next;
      if (bus.limit_we) begin
        r_limit <= bus.limit_in;
      end
    end
  end

  // Next-state selection with the per-state command priorities.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
        end else if (bus.step) begin
          w_next = S_STEP;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_next = S_IDLE;
        end else if (!bus.jmp_req && w_at_lim && !bus.wrap_en) begin
          w_next = S_DONE;
        end
      end
      S_STEP: begin
        w_next = S_IDLE;
      end
      S_DONE: begin
        if (bus.start) begin
          w_next = S_RUN;
        end else if (bus.jmp_req || bus.stop) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counter drive and jump handshake; sampled by the counter on the same edge.
  always_comb begin
    bus.enable  = 1'b0;
    bus.loact   = 1'b0;
    bus.load    = '0;
    bus.jmp_ack = 1'b0;
    bus.jmp_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.jmp_req) begin
          bus.loact   = w_jmp_ok;
          bus.load    = w_jmp_ok ? bus.jmp_addr : '0;
          bus.jmp_ack = w_jmp_ok;
          bus.jmp_err = !w_jmp_ok;
        end
      end
      S_RUN: begin
        if (!bus.stop) begin
          if (bus.jmp_req) begin
            bus.loact   = w_jmp_ok;
            bus.load    = w_jmp_ok ? bus.jmp_addr : '0;
            bus.jmp_ack = w_jmp_ok;
            bus.jmp_err = !w_jmp_ok;
          end else if (w_at_lim) begin
            bus.loact = bus.wrap_en;
          end else begin
            bus.enable = 1'b1;
          end
        end
      end
      S_STEP: begin
        if (!w_at_lim) begin
          bus.enable = 1'b1;
        end else begin
          bus.loact = bus.wrap_en;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          bus.loact = 1'b1;
        end else if (bus.jmp_req) begin
          bus.loact   = w_jmp_ok;
          bus.load    = w_jmp_ok ? bus.jmp_addr : '0;
          bus.jmp_ack = w_jmp_ok;
          bus.jmp_err = !w_jmp_ok;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cont12_ctrl.sv
// Scoreboard bench for cont12_ctrl: a behavioural model predicts every
// cycle's outputs and counter value; a negedge monitor compares them.
module tb_cont12_ctrl;
  localparam int W = 12;
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, DONE = 2'b11;

  typedef struct {
    logic         en;
    logic         la;
    logic [W-1:0] ld;
    logic         ack;
    logic         err;
    logic         busy;
    logic         done;
    logic [1:0]   st;
    logic [W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic cur_wrap = 1'b0;

  logic [1:0]   m_state;
  logic [W-1:0] m_limit;
  logic [W-1:0] m_cont;
  exp_t         sbq[$];

  always #5 clk = ~clk;

  cont12_ctrl_if #(.W(W)) bus ();

  cont12_ctrl #(.W(W), .DEFAULT_LIMIT(12'hFFF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // The counter being sequenced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.cont <= '0;
    else if (bus.loact) bus.cont <= bus.load;
    else if (bus.enable) bus.cont <= bus.cont + 1'b1;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // Apply the jump rule (accept when target <= limit) to an expectation.
  task automatic do_jump(inout exp_t e);
    if (bus.jmp_addr <= m_limit) begin
      e.la = 1'b1; e.ld = bus.jmp_addr; e.ack = 1'b1;
    end else begin
      e.err = 1'b1;
    end
  endtask

  // Predict this cycle from the current inputs, push it, advance the model.
  task automatic model_cycle();
    exp_t e;
    logic at_lim;
    logic [1:0] nst;
    e = '{en: 1'b0, la: 1'b0, ld: '0, ack: 1'b0, err: 1'b0,
          busy: 1'b0, done: 1'b0, st: m_state, cnt: m_cont};
    e.busy = (m_state == RUN) || (m_state == STEP);
    e.done = (m_state == DONE);
    at_lim = (m_cont >= m_limit);
    nst = m_state;
    case (m_state)
      IDLE: begin
        if (bus.jmp_req) do_jump(e);
        nst = bus.start ? RUN : (bus.step ? STEP : IDLE);
      end
      RUN: begin
        if (bus.stop) nst = IDLE;
        else if (bus.jmp_req) do_jump(e);
        else if (at_lim && cur_wrap) e.la = 1'b1;
        else if (at_lim) nst = DONE;
        else e.en = 1'b1;
      end
      STEP: begin
        nst = IDLE;
        if (!at_lim) e.en = 1'b1;
        else if (cur_wrap) e.la = 1'b1;
      end
      default: begin
        if (bus.start) begin e.la = 1'b1; nst = RUN; end
        else if (bus.jmp_req) begin do_jump(e); nst = IDLE; end
        else if (bus.stop) nst = IDLE;
      end
    endcase
    sbq.push_back(e);
    if (e.la) m_cont = e.ld;
    else if (e.en) m_cont = m_cont + 1'b1;
    if (bus.limit_we) m_limit = bus.limit_in;
    m_state = nst;
  endtask

  task automatic drive(input logic st, input logic sp, input logic stp, input logic jr,
                       input logic [W-1:0] ja, input logic lwe, input logic [W-1:0] lin);
    @(posedge clk); #1;
    bus.start = st; bus.stop = sp; bus.step = stp; bus.jmp_req = jr;
    bus.jmp_addr = ja; bus.limit_we = lwe; bus.limit_in = lin; bus.wrap_en = cur_wrap;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic model_reset();
    m_state = IDLE; m_limit = 12'hFFF; m_cont = '0;
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("enable",  W'(bus.enable),  W'(e.en));
        chk("loact",   W'(bus.loact),   W'(e.la));
        chk("load",    bus.load,        e.ld);
        chk("jmp_ack", W'(bus.jmp_ack), W'(e.ack));
        chk("jmp_err", W'(bus.jmp_err), W'(e.err));
        chk("busy",    W'(bus.busy),    W'(e.busy));
        chk("done",    W'(bus.done),    W'(e.done));
        chk("state",   W'(bus.state),   W'(e.st));
        chk("cont",    bus.cont,        e.cnt);
      end
    end
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.step = 0; bus.jmp_req = 0;
    bus.jmp_addr = '0; bus.limit_we = 0; bus.limit_in = '0; bus.wrap_en = 0;
    model_reset();
    #12;
    chk("rst_state",  W'(bus.state),  W'(IDLE));
    chk("rst_enable", W'(bus.enable), '0);
    chk("rst_busy",   W'(bus.busy),   '0);
    chk("rst_done",   W'(bus.done),   '0);
    chk("rst_loact",  W'(bus.loact),  '0);
    // A jump request during reset resolves against the IDLE/default-limit rules.
    bus.jmp_req = 1; bus.jmp_addr = 12'hFFF; #1;
    chk("rst_jmp_ack",   W'(bus.jmp_ack), W'(1'b1));
    chk("rst_jmp_load",  bus.load,        12'hFFF);
    bus.jmp_req = 0; bus.jmp_addr = '0;
    @(negedge clk); reset = 1'b1;

    // Limit 5, no wrap: 0..5, DONE holding 5, restart from 0.
    cur_wrap = 0;
    drive(0, 0, 0, 0, '0, 1, 12'h005);
    drive(1, 0, 0, 0, '0, 0, '0);
    idle(9);
    drive(1, 0, 0, 0, '0, 0, '0);
    idle(3);
    drive(0, 1, 0, 0, '0, 0, '0);
    idle(1);

    // Limit 3 with wrap: 0,1,2,3,0,1,...; then stop.
    cur_wrap = 1;
    drive(0, 0, 0, 0, '0, 1, 12'h003);
    drive(1, 0, 0, 0, '0, 0, '0);
    idle(11);
    drive(0, 1, 0, 0, '0, 0, '0);

    // IDLE at 7, three spaced steps.
    drive(0, 0, 0, 0, '0, 1, 12'hFFF);
    drive(0, 0, 0, 1, 12'h007, 0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, '0, 0, '0);
      idle(2);
    end

    // RUN with limit 0FF: accepted and rejected jumps.
    drive(0, 0, 0, 0, '0, 1, 12'h0FF);
    drive(1, 0, 0, 0, '0, 0, '0);
    idle(3);
    drive(0, 0, 0, 1, 12'h080, 0, '0);
    idle(2);
    drive(0, 0, 0, 1, 12'h100, 0, '0);
    idle(2);

    // Stop beats a simultaneous jump.
    drive(0, 0, 0, 1, 12'h050, 0, '0);
    drive(0, 1, 0, 1, 12'h070, 0, '0);
    idle(2);

    // Limit written below the running count, then reset mid-RUN.
    drive(0, 0, 0, 1, 12'h020, 0, '0);
    drive(1, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, '0, 1, 12'h010);
    idle(4);
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("midrst_state",  W'(bus.state),  W'(IDLE));
    chk("midrst_enable", W'(bus.enable), '0);
    chk("midrst_busy",   W'(bus.busy),   '0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    // Default limit restored: a jump to FFE is accepted.
    drive(0, 0, 0, 1, 12'hFFE, 0, '0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) cur_wrap = ~cur_wrap;
      drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 12,
            W'($urandom_range(0, 48)), $urandom_range(0, 99) < 4,
            W'($urandom_range(0, 40)));
    end
    idle(1);

    @(negedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cont12_ctrl.md
# cont12_ctrl

Run-control sequencer for the 12-bit loadable counter (clk/reset/enable/loact/load/cont). It owns the counter's `enable`, `loact` and `load` inputs. It runs the counter continuously, single-steps it, or stops it. It applies jump requests and terminates or wraps the count at a programmable limit. It sits between the front-panel/host control signals and the counter, and reads back the counter's `cont` output to make its decisions.

## Interface
- `W`, 12: counter width.
- `DEFAULT_LIMIT`, 12'hFFF: reset value of the limit register.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  start or resume continuous counting.
- `stop`  in  1  halt counting, return to IDLE.
- `step`  in  1  request a single increment.
- `jmp_req`  in  1  request to load the counter with `jmp_addr`.
- `jmp_addr`  in  W  jump target.
- `limit_we`  in  1  write `limit_in` into the limit register.
- `limit_in`  in  W  new terminal value.
- `wrap_en`  in  1  1 = reload 0 at limit; 0 = stop in DONE.
- `cont`  in  W  current counter value, fed back from the counter.
- `enable`  out  1  to counter enable.
- `loact`  out  1  to counter load-activate.
- `load`  out  W  to counter load value.
- `busy`  out  1  state is RUN or STEP.
- `done`  out  1  state is DONE (level).
- `jmp_ack`  out  1  jump applied this cycle.
- `jmp_err`  out  1  jump rejected this cycle (`jmp_addr` > limit).
- `state`  out  2  IDLE=00, RUN=01, STEP=10, DONE=11.

## Operation
- The state register and limit register are the only sequential elements.
- `enable`, `loact`, `load`, `jmp_ack` and `jmp_err` are combinational from state, inputs, limit and `cont`. The counter samples them on the same edge.
- Defaults are `enable`=0, `loact`=0 and `load`=0.
- `at_lim` = (`cont` >= limit), unsigned compare. This covers a limit written below the current count.
- Jump validity: the jump is valid when `jmp_addr` <= limit.
  - Valid: `loact`=1, `load`=`jmp_addr`, `jmp_ack`=1.
  - Invalid: `jmp_err`=1, no load.
- IDLE:
  - `jmp_req` is processed as above; nothing is incremented.
  - Next state is RUN if `start`, else STEP if `step`, else IDLE. `start` has priority over `step`.
  - `stop` is ignored.
- RUN, priority stop > jmp_req > at_lim > increment:
  - `stop`: no action, next state IDLE.
  - `jmp_req`: processed as above (load or reject), stay RUN, no increment.
  - `at_lim` with `wrap_en`=1: `loact`=1, `load`=0, stay RUN.
  - `at_lim` with `wrap_en`=0: no action, next state DONE.
  - Otherwise `enable`=1.
  - The count sequence is 0..limit inclusive.
- STEP, one cycle, always returns to IDLE:
  - Not `at_lim`: `enable`=1.
  - `at_lim` with `wrap_en`: `loact`=1, `load`=0.
  - `at_lim` without `wrap_en`: no action.
  - `jmp_req` and `stop` are ignored (no ack, no err).
- DONE:
  - `start`: `loact`=1, `load`=0, next state RUN (restart from 0).
  - Else `jmp_req`: processed as above, next state IDLE. An invalid jump also goes to IDLE.
  - Else `stop`: next state IDLE.
  - `start` has priority over `jmp_req`, which has priority over `stop`.
- Limit register: `limit_we` writes `limit_in` in any state. The new value is used from the next cycle; the current cycle compares against the old limit.
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE and limit to `DEFAULT_LIMIT`.
  - Combinational outputs resolve to IDLE values: `busy`=0, `done`=0, `state`=00, `enable`=0.
  - `loact`/`jmp_ack`/`jmp_err` are 0 unless `jmp_req` is asserted.
  - Reset asserted mid-RUN stops counting immediately. The counter itself is reset separately.

## Timing
- Command-to-counter latency is 0 cycles: the counter reflects an IDLE jump, or a RUN increment/jump/wrap, on the next rising edge.
- `start` in IDLE: first increment on the edge after the next one (1 cycle in IDLE, then RUN).
- `step` in IDLE: exactly one increment, occurring on the second edge after `step`.
- RUN with `wrap_en`=0 reaching limit L: `cont`=L is held. DONE is entered one edge later, and `cont` stays at L.
- RUN with `wrap_en`=1: `cont` goes L -> 0 in one edge, with no extra idle cycle.
- `jmp_ack`/`jmp_err` are single-cycle only while `jmp_req` is held in an accepting state. The requester deasserts after seeing either.

## Test plan
- Reset, limit 12'h005, `wrap_en`=0, `start` pulse:
  - `cont` goes 0,1,2,3,4,5.
  - `done`=1 with `cont`=5 held.
  - `start` again -> `cont`=0, then counting resumes.
- Limit 12'h003, `wrap_en`=1, RUN for 10 cycles -> `cont` sequence 0,1,2,3,0,1,2,3,0,1. `done` never asserts.
- IDLE at `cont`=7, three `step` pulses spaced 3 cycles apart -> `cont`=8, 9, 10. `busy` is high for one cycle per step.
- RUN, limit 12'h0FF, `jmp_req` with `jmp_addr`=12'h080:
  - `jmp_ack`=1 and `cont`=12'h080 next cycle, then 12'h081.
  - Repeat with `jmp_addr`=12'h100: `jmp_err`=1 and `cont` unchanged.
- RUN at `cont`=12'h050, `stop`+`jmp_req` same cycle -> `jmp_ack`=0, `state`=IDLE, `cont`=12'h050 held.
- RUN at `cont`=12'h020, write limit 12'h010 -> next cycle `at_lim`; with `wrap_en`=1, `cont`=0. Assert `reset`=0 mid-RUN -> `state`=00 and `enable`=0 immediately, limit=12'hFFF.
